bcd_updown_counter: RTL and testbench

//   Parametrised multi-digit up/down counter in radix RADIX, with enable,

---
 rtl/bcd_updown_counter.sv | 109 ++++++++++
 tb/tb_bcd_updown_counter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Multi-digit radix-RADIX up/down counter with enable, synchronous load,
// zero flag and wrap pulse. All outputs are a registered snapshot of the
// internal state, so they lag the count by one cycle and change together.
module bcd_updown_counter #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned RADIX  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   number,
  output logic                  zero,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam logic [3:0]  DIGIT_MAX = 4'(RADIX - 1);
  localparam logic [31:0] RADIX_W   = 32'(RADIX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         wrap_q;
  logic         wrap_d;
  logic         err_q;
  logic         err_d;

  // Next-state: load (with out-of-range digit scrub), else ripple step, else hold
  always_comb begin
    logic       chain;
    logic [3:0] dig;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    chain  = 1'b1;
    dig    = 4'd0;
    if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = load_val[4*i +: 4];
        if ({28'd0, dig} >= RADIX_W) begin
          cnt_d[4*i +: 4] = 4'd0;
          err_d           = 1'b1;
        end else begin
          cnt_d[4*i +: 4] = dig;
        end
      end
    end else if (en && mode) begin
      // chain stays set only while every lower digit sits at its maximum
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = cnt_q[4*i +: 4];
        if (chain) begin
          if (dig == DIGIT_MAX) begin
            cnt_d[4*i +: 4] = 4'd0;
          end else begin
            cnt_d[4*i +: 4] = dig + 4'd1;
            chain           = 1'b0;
          end
        end
      end
      wrap_d = chain;
    end else if (en) begin
      // chain stays set only while every lower digit sits at zero
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig = cnt_q[4*i +: 4];
        if (chain) begin
          if (dig == 4'd0) begin
            cnt_d[4*i +: 4] = DIGIT_MAX;
          end else begin
            cnt_d[4*i +: 4] = dig - 4'd1;
            chain           = 1'b0;
          end
        end
      end
      wrap_d = chain;
    end
  end

  // Internal count and pending pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  // Output snapshot stage, one cycle behind the internal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number   <= '0;
      zero     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      number   <= cnt_q;
      zero     <= (cnt_q == '0);
      wrap     <= wrap_q;
      load_err <= err_q;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter, DIGITS=2 RADIX=10.
module tb_bcd_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] number;
  logic       zero;
  logic       wrap;
  logic       load_err;

  int errors;
  int checks;

  bcd_updown_counter #(.DIGITS(2), .RADIX(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .number   (number),
    .zero     (zero),
    .wrap     (wrap),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  // One rising edge, then return at the following falling edge for sampling
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b1; load = 1'b0; load_val = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (number !== 8'h00 || zero !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got num=%h z=%b w=%b e=%b want 00 0 0 0", number, zero, wrap, load_err);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (zero !== 1'b0 || number !== 8'h00) begin
      errors++;
      $display("FAIL reset_cycle0 got num=%h z=%b want 00 0", number, zero);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (number !== 8'h00 || zero !== 1'b1 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle c=%0d got num=%h z=%b w=%b want 00 1 0", c, number, zero, wrap);
      end
    end
  endtask

  task automatic test_count_up();
    logic [7:0] exp_num;
    en = 1'b1; mode = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      exp_num = bcd((k - 1) % 100);
      checks++;
      if (number !== exp_num || wrap !== (k == 101) || zero !== (exp_num == 8'h00)) begin
        errors++;
        $display("FAIL count_up k=%0d got num=%h w=%b z=%b want %h %b %b",
                 k, number, wrap, zero, exp_num, (k == 101), (exp_num == 8'h00));
      end
    end
    // internal count is now 01; with en low the output settles and holds
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (number !== 8'h01 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL en_low_settle c=%0d got num=%h w=%b want 01 0", c, number, wrap);
      end
    end
  endtask

  task automatic test_count_down();
    logic [7:0] exp_num [3];
    logic       exp_w   [3];
    logic       exp_z   [3];
    exp_num = '{8'h00, 8'h99, 8'h98};
    exp_w   = '{1'b0, 1'b1, 1'b0};
    exp_z   = '{1'b1, 1'b0, 1'b0};
    load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0;
    tick();
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (number !== exp_num[k] || wrap !== exp_w[k] || zero !== exp_z[k]) begin
        errors++;
        $display("FAIL count_down k=%0d got num=%h w=%b z=%b want %h %b %b",
                 k, number, wrap, zero, exp_num[k], exp_w[k], exp_z[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] exp_num [3];
    exp_num = '{8'h47, 8'h48, 8'h49};
    load = 1'b1; load_val = 8'h47; en = 1'b1; mode = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) en = 1'b0;
      tick();
      checks++;
      if (number !== exp_num[k] || load_err !== 1'b0) begin
        errors++;
        $display("FAIL load k=%0d got num=%h e=%b want %h 0", k, number, load_err, exp_num[k]);
      end
    end
  endtask

  task automatic test_load_err();
    load = 1'b1; load_val = 8'hA5; en = 1'b0;
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (number !== 8'h05 || load_err !== 1'b1) begin
      errors++;
      $display("FAIL load_err_pulse got num=%h e=%b want 05 1", number, load_err);
    end
    tick();
    checks++;
    if (number !== 8'h05 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_clear got num=%h e=%b want 05 0", number, load_err);
    end
  endtask

  task automatic test_load_over_en();
    // load 99 twice with en=1 up: no step, so no wrap despite all-max digits
    load = 1'b1; load_val = 8'h99; en = 1'b1; mode = 1'b1;
    tick();
    tick();
    load = 1'b0; en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (number !== 8'h99 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL load_over_en c=%0d got num=%h w=%b want 99 0", c, number, wrap);
      end
    end
  endtask

  task automatic test_mode_toggle();
    logic [7:0] exp_num [5];
    logic       modes   [5];
    exp_num = '{8'h10, 8'h11, 8'h10, 8'h09, 8'h10};
    modes   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    load = 1'b1; load_val = 8'h10;
    tick();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      en   = (k < 4);
      mode = modes[k];
      tick();
      checks++;
      if (number !== exp_num[k]) begin
        errors++;
        $display("FAIL mode_toggle k=%0d got num=%h want %h", k, number, exp_num[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    // reach 63 with a load_err pulse still pending in the pipeline
    load = 1'b1; load_val = 8'h6F; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; mode = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (number !== 8'h62) begin
      errors++;
      $display("FAIL pre_reset got num=%h want 62", number);
    end
    load = 1'b1; load_val = 8'hF3; en = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (number !== 8'h00 || zero !== 1'b0 || wrap !== 1'b0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got num=%h z=%b w=%b e=%b want 00 0 0 0", number, zero, wrap, load_err);
    end
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; mode = 1'b1;
    tick();
    checks++;
    if (number !== 8'h00 || zero !== 1'b1 || load_err !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL restart0 got num=%h z=%b e=%b w=%b want 00 1 0 0", number, zero, load_err, wrap);
    end
    tick();
    checks++;
    if (number !== 8'h01 || zero !== 1'b0) begin
      errors++;
      $display("FAIL restart1 got num=%h z=%b want 01 0", number, zero);
    end
    en = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_load_err();
    test_load_over_en();
    test_mode_toggle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
